// File: rtl/sample_phrase_builder.sv
// Packs 8-bit audio samples into 128-bit, 16-sample phrases on an AXI-Stream master.
// The first phrase of a recording carries tuser; recording stops after MAX_PHRASES phrases.
module sample_phrase_builder #(
    parameter int MAX_PHRASES = 45000,
    parameter int DROP_W      = 16
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [7:0]        sample_in,
    input  logic              sample_valid_in,
    input  logic              record_start_in,
    output logic [127:0]      phrase_axis_data,
    output logic              phrase_axis_tuser,
    output logic              phrase_axis_valid,
    input  logic              phrase_axis_ready,
    output logic              overflow_out,
    output logic [DROP_W-1:0] drop_count_out,
    output logic [15:0]       phrase_count_out,
    output logic [1:0]        state_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] MAX_C = 16'(MAX_PHRASES);

    state_t              state_r;
    logic [127:0]        asm_r;
    logic [3:0]          slot_r;
    logic                pending_r;
    logic                tuser_arm_r;
    logic [127:0]        data_r;
    logic                tuser_r;
    logic                valid_r;
    logic                overflow_r;
    logic [DROP_W-1:0]   drop_r;
    logic [15:0]         count_r;

    logic                out_free_s;
    logic                fill_s;
    logic                complete_s;
    logic                load_pend_s;
    logic                load_new_s;
    logic                load_s;
    logic                accept_s;
    logic                drop_s;
    logic                last_load_s;
    logic [127:0]        load_data_s;

    // A restart takes priority over everything the assembly would otherwise do this cycle.
    assign out_free_s  = !valid_r || phrase_axis_ready;
    assign fill_s      = (state_r == ST_FILL) && !record_start_in;
    assign complete_s  = fill_s && !pending_r && sample_valid_in && (slot_r == 4'd15);
    assign load_pend_s = fill_s && pending_r && out_free_s;
    assign load_new_s  = complete_s && out_free_s;
    assign load_s      = load_pend_s || load_new_s;
    assign accept_s    = fill_s && sample_valid_in && (!pending_r || out_free_s);
    assign drop_s      = fill_s && sample_valid_in && pending_r && !out_free_s;
    assign last_load_s = load_s && ((count_r + 16'd1) == MAX_C);
    assign load_data_s = pending_r ? asm_r : {sample_in, asm_r[119:0]};

    // Recording state machine, phrase counter, drop accounting and tuser arming
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r     <= ST_IDLE;
            pending_r   <= 1'b0;
            tuser_arm_r <= 1'b0;
            overflow_r  <= 1'b0;
            drop_r      <= {DROP_W{1'b0}};
            count_r     <= 16'd0;
        end else if (record_start_in) begin
            state_r     <= ST_FILL;
            pending_r   <= 1'b0;
            tuser_arm_r <= 1'b1;
            overflow_r  <= 1'b0;
            drop_r      <= {DROP_W{1'b0}};
            count_r     <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: state_r <= ST_IDLE;
                ST_FILL: state_r <= last_load_s ? ST_DONE : ST_FILL;
                ST_DONE: state_r <= ST_DONE;
                default: state_r <= ST_IDLE;
            endcase
            if (load_pend_s) begin
                pending_r <= 1'b0;
            end else if (complete_s && !out_free_s) begin
                pending_r <= 1'b1;
            end else begin
                pending_r <= pending_r;
            end
            if (load_s) begin
                tuser_arm_r <= 1'b0;
                count_r     <= count_r + 16'd1;
            end else begin
                tuser_arm_r <= tuser_arm_r;
                count_r     <= count_r;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_r != {DROP_W{1'b1}}) begin
                    drop_r <= drop_r + {{(DROP_W-1){1'b0}}, 1'b1};
                end else begin
                    drop_r <= drop_r;
                end
            end else begin
                overflow_r <= overflow_r;
                drop_r     <= drop_r;
            end
        end
    end

    // Assembly register and slot index; a pending phrase leaves slot_r at 0 so a
    // sample arriving as it drains lands in slot 0.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            asm_r  <= 128'd0;
            slot_r <= 4'd0;
        end else if (record_start_in) begin
            if (sample_valid_in) begin
                asm_r[7:0] <= sample_in;
                slot_r     <= 4'd1;
            end else begin
                slot_r     <= 4'd0;
            end
        end else if (accept_s) begin
            asm_r[{slot_r, 3'b000} +: 8] <= sample_in;
            slot_r                       <= slot_r + 4'd1;
        end else begin
            slot_r <= slot_r;
        end
    end

    // Single-entry output register; survives a restart so the held phrase keeps its tuser
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            data_r  <= 128'd0;
            tuser_r <= 1'b0;
            valid_r <= 1'b0;
        end else if (load_s) begin
            data_r  <= load_data_s;
            tuser_r <= tuser_arm_r;
            valid_r <= 1'b1;
        end else if (valid_r && phrase_axis_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign phrase_axis_data  = data_r;
    assign phrase_axis_tuser = tuser_r;
    assign phrase_axis_valid = valid_r;
    assign overflow_out      = overflow_r;
    assign drop_count_out    = drop_r;
    assign phrase_count_out  = count_r;
    assign state_out         = state_r;

endmodule

// File: tb/tb_sample_phrase_builder.sv
// Directed bench for sample_phrase_builder, built with a 4-phrase recording length.
module tb_sample_phrase_builder;

    logic         clk_in;
    logic         rst_n_in;
    logic [7:0]   sample_in;
    logic         sample_valid_in;
    logic         record_start_in;
    logic [127:0] phrase_axis_data;
    logic         phrase_axis_tuser;
    logic         phrase_axis_valid;
    logic         phrase_axis_ready;
    logic         overflow_out;
    logic [15:0]  drop_count_out;
    logic [15:0]  phrase_count_out;
    logic [1:0]   state_out;

    int checks_r;
    int failures_r;
    int nval_r;

    sample_phrase_builder #(.MAX_PHRASES(4), .DROP_W(16)) dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .sample_in         (sample_in),
        .sample_valid_in   (sample_valid_in),
        .record_start_in   (record_start_in),
        .phrase_axis_data  (phrase_axis_data),
        .phrase_axis_tuser (phrase_axis_tuser),
        .phrase_axis_valid (phrase_axis_valid),
        .phrase_axis_ready (phrase_axis_ready),
        .overflow_out      (overflow_out),
        .drop_count_out    (drop_count_out),
        .phrase_count_out  (phrase_count_out),
        .state_out         (state_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks_r++;
        if (got !== exp) begin
            failures_r++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock with the given inputs; returns #1 after the edge with inputs idle.
    task automatic cyc(input logic [7:0] s, input logic v, input logic st);
        sample_in       = s;
        sample_valid_in = v;
        record_start_in = st;
        @(posedge clk_in);
        #1;
        sample_in       = 8'h00;
        sample_valid_in = 1'b0;
        record_start_in = 1'b0;
    endtask

    task automatic feed(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) cyc(8'(int'(base) + i), 1'b1, 1'b0);
    endtask

    function automatic logic [127:0] mk_phrase(input logic [7:0] base);
        logic [127:0] r;
        r = 128'd0;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = 8'(int'(base) + k);
        return r;
    endfunction

    initial begin
        checks_r          = 0;
        failures_r        = 0;
        rst_n_in          = 1'b0;
        sample_in         = 8'h00;
        sample_valid_in   = 1'b0;
        record_start_in   = 1'b0;
        phrase_axis_ready = 1'b1;

        // Reset state
        #28;
        check_val("rst_valid", 128'(phrase_axis_valid), 128'd0);
        check_val("rst_data", phrase_axis_data, 128'd0);
        check_val("rst_tuser", 128'(phrase_axis_tuser), 128'd0);
        check_val("rst_ovf", 128'(overflow_out), 128'd0);
        check_val("rst_drop", 128'(drop_count_out), 128'd0);
        check_val("rst_count", 128'(phrase_count_out), 128'd0);
        check_val("rst_state", 128'(state_out), 128'd0);
        #2 rst_n_in = 1'b1;

        // Samples ignored in IDLE
        feed(8'h00, 16);
        check_val("idle_valid", 128'(phrase_axis_valid), 128'd0);
        check_val("idle_state", 128'(state_out), 128'd0);

        // Basic packing
        cyc(8'h00, 1'b0, 1'b1);
        check_val("start_state", 128'(state_out), 128'd1);
        feed(8'h00, 15);
        check_val("basic_not_yet", 128'(phrase_axis_valid), 128'd0);
        cyc(8'h0F, 1'b1, 1'b0);
        check_val("basic_valid", 128'(phrase_axis_valid), 128'd1);
        check_val("basic_data", phrase_axis_data, 128'h0F0E0D0C0B0A09080706050403020100);
        check_val("basic_tuser", 128'(phrase_axis_tuser), 128'd1);
        check_val("basic_count", 128'(phrase_count_out), 128'd1);
        cyc(8'h00, 1'b0, 1'b0);
        check_val("basic_one_cycle", 128'(phrase_axis_valid), 128'd0);
        feed(8'h10, 16);
        check_val("basic2_valid", 128'(phrase_axis_valid), 128'd1);
        check_val("basic2_data", phrase_axis_data, 128'h1F1E1D1C1B1A19181716151413121110);
        check_val("basic2_tuser", 128'(phrase_axis_tuser), 128'd0);
        cyc(8'h00, 1'b0, 1'b0);
        check_val("basic2_fall", 128'(phrase_axis_valid), 128'd0);

        // Backpressure: phrase 1 held, phrase 2 pending, 16 drops
        phrase_axis_ready = 1'b0;
        cyc(8'h00, 1'b0, 1'b1);
        feed(8'h40, 48);
        check_val("bp_valid", 128'(phrase_axis_valid), 128'd1);
        check_val("bp_data1", phrase_axis_data, mk_phrase(8'h40));
        check_val("bp_tuser1", 128'(phrase_axis_tuser), 128'd1);
        check_val("bp_drop", 128'(drop_count_out), 128'd16);
        check_val("bp_ovf", 128'(overflow_out), 128'd1);
        check_val("bp_count", 128'(phrase_count_out), 128'd1);
        phrase_axis_ready = 1'b1;
        cyc(8'h77, 1'b1, 1'b0);
        check_val("bp_valid2", 128'(phrase_axis_valid), 128'd1);
        check_val("bp_data2", phrase_axis_data, mk_phrase(8'h50));
        check_val("bp_tuser2", 128'(phrase_axis_tuser), 128'd0);
        check_val("bp_count2", 128'(phrase_count_out), 128'd2);
        check_val("bp_drain_accept", 128'(drop_count_out), 128'd16);
        cyc(8'h00, 1'b0, 1'b0);
        check_val("bp_fall", 128'(phrase_axis_valid), 128'd0);

        // Record length of 4 phrases
        cyc(8'h00, 1'b0, 1'b1);
        nval_r = 0;
        for (int i = 0; i < 80; i++) begin
            cyc(8'(i), 1'b1, 1'b0);
            if (phrase_axis_valid) nval_r++;
            if (i == 47) check_val("len_state_mid", 128'(state_out), 128'd1);
            if (i == 63) begin
                check_val("len_state_done", 128'(state_out), 128'd2);
                check_val("len_count", 128'(phrase_count_out), 128'd4);
                check_val("len_data4", phrase_axis_data, mk_phrase(8'd48));
            end
        end
        check_val("len_phrases", 128'(nval_r), 128'd4);
        check_val("len_drop", 128'(drop_count_out), 128'd0);
        check_val("len_state_end", 128'(state_out), 128'd2);
        check_val("len_valid_end", 128'(phrase_axis_valid), 128'd0);

        // Restart mid-phrase with sample on the start cycle
        cyc(8'h00, 1'b0, 1'b1);
        check_val("rs_state", 128'(state_out), 128'd1);
        feed(8'h01, 5);
        cyc(8'hAA, 1'b1, 1'b1);
        feed(8'hB1, 15);
        check_val("rs_valid", 128'(phrase_axis_valid), 128'd1);
        check_val("rs_data", phrase_axis_data, 128'hBFBEBDBCBBBAB9B8B7B6B5B4B3B2B1AA);
        check_val("rs_tuser", 128'(phrase_axis_tuser), 128'd1);
        check_val("rs_count", 128'(phrase_count_out), 128'd1);

        // Restart with output occupied by a tuser=0 phrase and a pending one behind it
        cyc(8'h00, 1'b0, 1'b1);
        feed(8'hC0, 16);
        cyc(8'h00, 1'b0, 1'b0);
        phrase_axis_ready = 1'b0;
        feed(8'hD0, 16);
        check_val("ro_tuser_held", 128'(phrase_axis_tuser), 128'd0);
        feed(8'hE0, 18);
        check_val("ro_drop_pre", 128'(drop_count_out), 128'd2);
        cyc(8'h00, 1'b0, 1'b1);
        check_val("ro_valid", 128'(phrase_axis_valid), 128'd1);
        check_val("ro_data", phrase_axis_data, mk_phrase(8'hD0));
        check_val("ro_tuser", 128'(phrase_axis_tuser), 128'd0);
        check_val("ro_drop", 128'(drop_count_out), 128'd0);
        check_val("ro_ovf", 128'(overflow_out), 128'd0);
        check_val("ro_count", 128'(phrase_count_out), 128'd0);
        phrase_axis_ready = 1'b1;
        cyc(8'h00, 1'b0, 1'b0);
        check_val("ro_discard", 128'(phrase_axis_valid), 128'd0);
        feed(8'h30, 16);
        check_val("ro_new_data", phrase_axis_data, mk_phrase(8'h30));
        check_val("ro_new_tuser", 128'(phrase_axis_tuser), 128'd1);

        // Asynchronous reset between edges
        phrase_axis_ready = 1'b0;
        cyc(8'h00, 1'b0, 1'b1);
        feed(8'h80, 16);
        check_val("ar_pre_valid", 128'(phrase_axis_valid), 128'd1);
        #2 rst_n_in = 1'b0;
        #1;
        check_val("ar_valid", 128'(phrase_axis_valid), 128'd0);
        check_val("ar_count", 128'(phrase_count_out), 128'd0);
        check_val("ar_state", 128'(state_out), 128'd0);
        check_val("ar_data", phrase_axis_data, 128'd0);
        #2 rst_n_in = 1'b1;
        phrase_axis_ready = 1'b1;
        feed(8'h90, 16);
        check_val("ar_ignored", 128'(phrase_axis_valid), 128'd0);
        check_val("ar_idle", 128'(state_out), 128'd0);
        cyc(8'h00, 1'b0, 1'b1);
        feed(8'hA0, 16);
        check_val("ar_after_valid", 128'(phrase_axis_valid), 128'd1);
        check_val("ar_after_data", phrase_axis_data, mk_phrase(8'hA0));
        check_val("ar_after_tuser", 128'(phrase_axis_tuser), 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
